n101_icb2axi_bridge: RTL and testbench
======================================

// Module: n101_icb2axi_bridge
// PURPOSE
//  Single-outstanding ICB-to-AXI master bridge; the stage directly upstream of the peripheral AXI slaves.
//  Accepts one ICB command, issues one single-beat AXI read (AR/R) or write (AW/W/B), returns one ICB response.
//  Tolerates slaves that tie ARREADY to RREADY / WREADY to BREADY (R/B may complete in same cycle as AR/W).
// PARAMETERS
//  AW  32  address width (ICB and AXI)
//  DW  32  data width (ICB and AXI); wmask/wstrb width DW/8
// PORTS
//  clk              in   1       clock; all logic rising-edge
//  rst              in   1       synchronous active-high reset
//  icb_cmd_valid    in   1       ICB command valid
//  icb_cmd_ready    out  1       ICB command ready
//  icb_cmd_addr     in   AW      byte address
//  icb_cmd_read     in   1       1=read, 0=write
//  icb_cmd_wdata    in   DW      write data
//  icb_cmd_wmask    in   DW/8    byte write enables
//  icb_cmd_size     in   2       0=byte,1=half,2=word
//  icb_rsp_valid    out  1       ICB response valid
//  icb_rsp_ready    in   1       ICB response ready
//  icb_rsp_rdata    out  DW      read data (0 for writes)
//  icb_rsp_err      out  1       error flag
//  axi_ar*/aw*      out  -       valid,addr(AW),cache[3:0],prot[2:0],lock[1:0],burst[1:0],len[3:0],size[2:0]; ready in
//  axi_w*           out  -       wvalid, wdata(DW), wstrb(DW/8), wlast; wready in
//  axi_r*           in   -       rvalid, rdata(DW), rresp[1:0], rlast; rready out
//  axi_b*           in   -       bvalid, bresp[1:0]; bready out
// BEHAVIOUR
//  FSM states IDLE, RD, WR, RSP. Reset: state=IDLE, all *valid=0, rready=bready=0, rsp_rdata=0, rsp_err=0.
//  icb_cmd_ready = (state==IDLE). On cmd handshake: capture addr/wdata/wmask/size/read; clear ar/aw/w/r/b done flags;
//   go RD (read) or WR (write). AXI valids assert the cycle after the handshake (1-cycle issue latency).
//  RD: arvalid = !ar_done; rready = !r_done. ar_done set on arvalid&arready; r_done set on rvalid&rready,
//   capturing rdata and err=rresp[1]. Both may set in the same cycle. When ar_done&r_done (incl. same cycle) -> RSP.
//  WR: awvalid=!aw_done, wvalid=!w_done (independent; either order or same cycle); bready=!b_done.
//   b_done set on bvalid&bready capturing err=bresp[1]; B accepted even if coincident with W handshake.
//   When aw_done&w_done&b_done -> RSP; rsp_rdata=0.
//  RSP: icb_rsp_valid=1, data/err held stable until icb_rsp_ready; then IDLE. Next cmd accepted no earlier
//   than the cycle after the rsp handshake (min 3 cycles cmd->rsp with zero-wait slave).
//  Constants: len=0, burst=2'b01, lock=0, cache=4'b0000, prot=3'b000, wlast=1; ar/awsize={1'b0,icb_cmd_size}.
//  wdata/wstrb driven from captured wdata/wmask unmodified; araddr/awaddr = captured addr unmodified.
//  rvalid/bvalid outside RD/WR ignored (ready low). rresp/bresp 2'b10 or 2'b11 -> err=1; 2'b00/01 -> err=0.
//  rlast ignored (single beat). Reset mid-transaction: returns to IDLE next edge, all valids drop, no response.
//  Outputs are registered (no combinational ready->valid path).
// CONFIGURATION
//  N101_ICB2AXI_ALIGN_CHK_EN defined: in IDLE on cmd handshake, if misaligned (size1 & addr[0], size2 & addr[1:0]!=0,
//   or size3) go straight to RSP with err=1, rdata=0; no AXI channel asserted.
//  Not defined: no check; every command forwarded to AXI as-is.
// TESTING
//  Read addr 0x1000, slave arready=1, rvalid same cycle rdata=0xA5A5_0001 -> one AR beat, rsp rdata=0xA5A5_0001 err=0.
//  Write 0x2004 data 0xDEADBEEF mask 4'hF, slave with wready=bready, bvalid=wvalid -> AW/W/B once, rsp err=0 rdata=0.
//  Write with awready delayed 5 cycles, W/B immediate -> awvalid held 5 cycles, rsp only after AW handshake.
//  Read with rresp=2'b10 and icb_rsp_ready low 4 cycles -> rsp_valid/err=1 held stable 4 cycles, then IDLE.
//  rst pulsed while RD waiting on arready -> next cycle arvalid=0, cmd_ready=1, no rsp_valid.
//  ALIGN_CHK_EN: word read at 0x1002 -> err=1 rsp, arvalid never asserted; without macro -> AR issued to 0x1002.

Source files
------------

// File: rtl/n101_icb2axi_bridge_if.sv
// ----------------------------------------------------------------------------
// n101_icb2axi_bridge_if
//   Bundles the ICB command/response channels and the five AXI channels that
//   surround the ICB-to-AXI bridge.
//   Modports:
//     master - the bridge itself: ICB target and single-beat AXI master
//              (drives icb_cmd_ready, icb_rsp_*, axi_ar*/aw*/w*, axi_rready,
//              axi_bready).
//     slave  - the surroundings: the ICB requester plus the AXI slave
//              (drives icb_cmd_*, icb_rsp_ready, axi_*ready, axi_r*, axi_b*).
//   Parameters: AW address width, DW data width (strobe width DW/8).
// ----------------------------------------------------------------------------
interface n101_icb2axi_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // ICB command
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic [1:0]      icb_cmd_size;
  // ICB response
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic [DW-1:0]   icb_rsp_rdata;
  logic            icb_rsp_err;
  // AXI read address
  logic            axi_arvalid;
  logic            axi_arready;
  logic [AW-1:0]   axi_araddr;
  logic [3:0]      axi_arcache;
  logic [2:0]      axi_arprot;
  logic [1:0]      axi_arlock;
  logic [1:0]      axi_arburst;
  logic [3:0]      axi_arlen;
  logic [2:0]      axi_arsize;
  // AXI write address
  logic            axi_awvalid;
  logic            axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [3:0]      axi_awcache;
  logic [2:0]      axi_awprot;
  logic [1:0]      axi_awlock;
  logic [1:0]      axi_awburst;
  logic [3:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  // AXI write data
  logic            axi_wvalid;
  logic            axi_wready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  // AXI read data
  logic            axi_rvalid;
  logic            axi_rready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast;
  // AXI write response
  logic            axi_bvalid;
  logic            axi_bready;
  logic [1:0]      axi_bresp;

  modport master (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_cmd_size, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    output axi_arvalid, axi_araddr, axi_arcache, axi_arprot, axi_arlock,
           axi_arburst, axi_arlen, axi_arsize,
    input  axi_arready,
    output axi_awvalid, axi_awaddr, axi_awcache, axi_awprot, axi_awlock,
           axi_awburst, axi_awlen, axi_awsize,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready,
    input  axi_bvalid, axi_bresp,
    output axi_bready
  );

  modport slave (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_cmd_size, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    input  axi_arvalid, axi_araddr, axi_arcache, axi_arprot, axi_arlock,
           axi_arburst, axi_arlen, axi_arsize,
    output axi_arready,
    input  axi_awvalid, axi_awaddr, axi_awcache, axi_awprot, axi_awlock,
           axi_awburst, axi_awlen, axi_awsize,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready,
    output axi_bvalid, axi_bresp,
    input  axi_bready
  );
endinterface

// File: rtl/n101_icb2axi_bridge.sv
// ----------------------------------------------------------------------------
// n101_icb2axi_bridge
//   Single-outstanding ICB-to-AXI master bridge. Accepts one ICB command,
//   issues one single-beat AXI read (AR/R) or write (AW/W/B), and returns one
//   ICB response before accepting the next command.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - n101_icb2axi_bridge_if.master (ICB cmd/rsp + AXI AR/AW/W/R/B)
//   Optional feature:
//     N101_ICB2AXI_ALIGN_CHK_EN - when defined, misaligned commands are
//     answered directly with err=1 and never reach AXI.
//   Slaves that tie ARREADY to RREADY (or WREADY to BREADY) are tolerated:
//   R/B may complete in the same cycle as AR/W.
// ----------------------------------------------------------------------------
module n101_icb2axi_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  n101_icb2axi_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t state, next_state;

  // Per-channel completion flags for the transaction in flight.
  logic ar_done, r_done, aw_done, w_done, b_done;

  // Command captured at the ICB handshake.
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [1:0]      size_q;

  // Response held until the ICB response handshake.
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;

  logic arvalid, awvalid, wvalid, rready, bready;
  logic cmd_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic misaligned;

  // Only the error bit of each response and no burst marker are meaningful
  // for a single-beat master.
  logic unused_bits;
  assign unused_bits = ^{bus.axi_rresp[0], bus.axi_bresp[0], bus.axi_rlast};

  // All handshake outputs derive from registered state only, so there is no
  // combinational path from any ready input to any valid output.
  assign arvalid = (state == RD) && !ar_done;
  assign rready  = (state == RD) && !r_done;
  assign awvalid = (state == WR) && !aw_done;
  assign wvalid  = (state == WR) && !w_done;
  assign bready  = (state == WR) && !b_done;

  assign cmd_hs = bus.icb_cmd_valid && (state == IDLE);
  assign ar_hs  = arvalid && bus.axi_arready;
  assign r_hs   = rready  && bus.axi_rvalid;
  assign aw_hs  = awvalid && bus.axi_awready;
  assign w_hs   = wvalid  && bus.axi_wready;
  assign b_hs   = bready  && bus.axi_bvalid;

`ifdef N101_ICB2AXI_ALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.icb_cmd_size)
      2'd1:    misaligned = bus.icb_cmd_addr[0];
      2'd2:    misaligned = |bus.icb_cmd_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // ICB side
  assign bus.icb_cmd_ready = (state == IDLE);
  assign bus.icb_rsp_valid = (state == RSP);
  assign bus.icb_rsp_rdata = rsp_rdata_q;
  assign bus.icb_rsp_err   = rsp_err_q;

  // AXI read address
  assign bus.axi_arvalid = arvalid;
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_arcache = 4'b0000;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_arlock  = 2'b00;
  assign bus.axi_arburst = 2'b01;
  assign bus.axi_arlen   = 4'd0;
  assign bus.axi_arsize  = {1'b0, size_q};

  // AXI write address
  assign bus.axi_awvalid = awvalid;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_awcache = 4'b0000;
  assign bus.axi_awprot  = 3'b000;
  assign bus.axi_awlock  = 2'b00;
  assign bus.axi_awburst = 2'b01;
  assign bus.axi_awlen   = 4'd0;
  assign bus.axi_awsize  = {1'b0, size_q};

  // AXI write data, read data, write response
  assign bus.axi_wvalid = wvalid;
  assign bus.axi_wdata  = wdata_q;
  assign bus.axi_wstrb  = wmask_q;
  assign bus.axi_wlast  = 1'b1;
  assign bus.axi_rready = rready;
  assign bus.axi_bready = bready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of a combinational process gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_hs) begin
        if (misaligned)             next_state = RSP;
        else if (bus.icb_cmd_read)  next_state = RD;
        else                        next_state = WR;
      end
      // Channel completions in the current cycle count alongside earlier
      // ones, so AR and R (or W and B) finishing together still advance.
      RD:  if ((ar_done || ar_hs) && (r_done || r_hs)) next_state = RSP;
      WR:  if ((aw_done || aw_hs) && (w_done || w_hs) && (b_done || b_hs))
             next_state = RSP;
      RSP: if (bus.icb_rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: this datapath is a handful of flops, not a memory, so it is reset
  // outright; that keeps the response registers at zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_done     <= 1'b0;
      r_done      <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      b_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      size_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q      <= bus.icb_cmd_addr;
        wdata_q     <= bus.icb_cmd_wdata;
        wmask_q     <= bus.icb_cmd_wmask;
        size_q      <= bus.icb_cmd_size;
        ar_done     <= 1'b0;
        r_done      <= 1'b0;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        b_done      <= 1'b0;
        // Writes report zero data; a rejected misaligned command reports err.
        rsp_rdata_q <= '0;
        rsp_err_q   <= misaligned;
      end
      if (ar_hs) ar_done <= 1'b1;
      if (r_hs) begin
        r_done      <= 1'b1;
        rsp_rdata_q <= bus.axi_rdata;
        rsp_err_q   <= bus.axi_rresp[1];
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        b_done    <= 1'b1;
        rsp_err_q <= bus.axi_bresp[1];
      end
    end
  end

endmodule

// File: tb/tb_n101_icb2axi_bridge.sv
// ----------------------------------------------------------------------------
// tb_n101_icb2axi_bridge
//   Directed, table-driven bench for n101_icb2axi_bridge. A behavioural AXI
//   slave reacts on the falling edge; the main thread drives ICB stimulus and
//   samples 1 ns after the falling edge, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_n101_icb2axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  n101_icb2axi_bridge_if bus ();

  n101_icb2axi_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AXI slave ----------------
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00;
  logic [1:0]  s_bresp = 2'b00;
  int          ar_stall = 0;
  int          aw_stall = 0;
  int          aw_stall_seen = 0;
  int          ar_n = 0, aw_n = 0, w_n = 0, b_n = 0, const_bad = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_size = '0;
  logic        ar_got = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;

  initial begin
    bus.axi_arready = 1'b0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rresp   = 2'b00;
    bus.axi_rlast   = 1'b1;
    bus.axi_bvalid  = 1'b0;
    bus.axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      // fold in handshakes that completed at the rising edge just past
      if (rst || bus.icb_cmd_ready) begin
        ar_got = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        ar_got = ar_got | p_ar; aw_got = aw_got | p_aw; w_got = w_got | p_w;
      end
      bus.axi_arready = (ar_stall == 0);
      bus.axi_awready = (aw_stall == 0);
      bus.axi_wready  = 1'b1;
      if (bus.axi_arvalid && ar_stall > 0) ar_stall--;
      if (bus.axi_awvalid && aw_stall > 0) begin
        aw_stall--;
        aw_stall_seen++;
      end
      p_ar = bus.axi_arvalid && bus.axi_arready;
      p_aw = bus.axi_awvalid && bus.axi_awready;
      p_w  = bus.axi_wvalid  && bus.axi_wready;
      bus.axi_rvalid = bus.axi_rready && (ar_got || p_ar);
      bus.axi_rdata  = s_rdata;
      bus.axi_rresp  = s_rresp;
      bus.axi_bvalid = bus.axi_bready && (aw_got || p_aw) && (w_got || p_w);
      bus.axi_bresp  = s_bresp;
      if (p_ar) begin
        ar_n++;
        last_addr = bus.axi_araddr;
        last_size = bus.axi_arsize;
        if (bus.axi_arlen != 4'd0 || bus.axi_arburst != 2'b01 ||
            bus.axi_arcache != 4'd0 || bus.axi_arprot != 3'd0 ||
            bus.axi_arlock != 2'd0) const_bad++;
      end
      if (p_aw) begin
        aw_n++;
        last_addr = bus.axi_awaddr;
        last_size = bus.axi_awsize;
        if (bus.axi_awlen != 4'd0 || bus.axi_awburst != 2'b01 ||
            bus.axi_awcache != 4'd0 || bus.axi_awprot != 3'd0 ||
            bus.axi_awlock != 2'd0) const_bad++;
      end
      if (p_w) begin
        w_n++;
        last_wdata = bus.axi_wdata;
        last_wstrb = bus.axi_wstrb;
        if (bus.axi_wlast !== 1'b1) const_bad++;
      end
      if (bus.axi_bvalid && bus.axi_bready) b_n++;
    end
  end

  // ---------------- ICB driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; aw_stall_seen = 0;
  endtask

  // Returns positioned at the first sample point after the command handshake.
  task automatic issue(input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [1:0] size);
    int waited;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
    bus.icb_cmd_size  = size;
    waited = 0;
    while (!bus.icb_cmd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!bus.icb_cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
    step();
    bus.icb_cmd_valid = 1'b0;
  endtask

  // lat counts sample points after the command handshake edge.
  task automatic wait_rsp(output int lat, output logic [31:0] rdata,
                          output logic err, output logic seen);
    lat = 1;
    while (!bus.icb_rsp_valid && lat < 60) begin
      step();
      lat++;
    end
    seen  = bus.icb_rsp_valid;
    rdata = bus.icb_rsp_rdata;
    err   = bus.icb_rsp_err;
    if (!seen) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err, seen;
    int          stable;
    int          rsp_early;

    vecs[0] = '{1'b1, 32'h0000_1000, 32'h0,         4'h0,    2'd2, 32'hA5A5_0001, 2'b00, 32'hA5A5_0001, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF,    2'd2, 32'h0,         2'b00, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 32'h0000_3002, 32'h0,         4'h0,    2'd1, 32'h1234_5678, 2'b01, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_4000, 32'h0,         4'h0,    2'd2, 32'hCAFE_0000, 2'b11, 32'hCAFE_0000, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_5001, 32'h0000_00AB, 4'b0010, 2'd0, 32'h0,         2'b10, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h0000_6000, 32'h0102_0304, 4'b1100, 2'd2, 32'h0,         2'b01, 32'h0,         1'b0};

    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_cmd_size  = '0;
    bus.icb_rsp_ready = 1'b1;

    // ---- reset state ----
    repeat (3) step();
    check("reset_flags",
          {56'd0, bus.icb_cmd_ready, bus.axi_arvalid, bus.axi_awvalid,
           bus.axi_wvalid, bus.axi_rready, bus.axi_bready, bus.icb_rsp_valid,
           bus.icb_rsp_err},
          64'h80);
    check("reset_rdata", {32'd0, bus.icb_rsp_rdata}, 64'd0);
    rst = 1'b0;
    step();

    // ---- table of zero-wait transactions ----
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      s_rdata = vecs[i].s_rdata;
      s_rresp = vecs[i].s_resp;
      s_bresp = vecs[i].s_resp;
      issue(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
            vecs[i].size);
      wait_rsp(lat, rdata, err, seen);
      step();
      check($sformatf("v%0d_rdata", i), {32'd0, rdata}, {32'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, 64'd2);
      check($sformatf("v%0d_addr", i), {32'd0, last_addr}, {32'd0, vecs[i].addr});
      check($sformatf("v%0d_size", i), {61'd0, last_size}, {61'd0, 1'b0, vecs[i].size});
      if (vecs[i].rd) begin
        check($sformatf("v%0d_beats", i), {ar_n[15:0], aw_n[15:0], w_n[15:0], b_n[15:0]},
              {16'd1, 16'd0, 16'd0, 16'd0});
      end else begin
        check($sformatf("v%0d_beats", i), {ar_n[15:0], aw_n[15:0], w_n[15:0], b_n[15:0]},
              {16'd0, 16'd1, 16'd1, 16'd1});
        check($sformatf("v%0d_wdata", i), {28'd0, last_wstrb, last_wdata},
              {28'd0, vecs[i].wmask, vecs[i].wdata});
      end
      check($sformatf("v%0d_idle", i), {63'd0, bus.icb_cmd_ready}, 64'd1);
    end
    check("axi_constants", const_bad, 64'd0);

    // ---- write with AW held off five cycles ----
    clear_counts();
    s_bresp   = 2'b00;
    aw_stall  = 5;
    rsp_early = 0;
    issue(1'b0, 32'h0000_7000, 32'h5555_AAAA, 4'hF, 2'd2);
    lat = 1;
    while (!bus.icb_rsp_valid && lat < 60) begin
      step();
      lat++;
    end
    if (bus.icb_rsp_valid && aw_n == 0) rsp_early++;
    check("awstall_rsp_seen", {63'd0, bus.icb_rsp_valid}, 64'd1);
    check("awstall_err", {63'd0, bus.icb_rsp_err}, 64'd0);
    step();
    check("awstall_cycles", aw_stall_seen, 64'd5);
    check("awstall_beats", {aw_n[15:0], w_n[15:0], b_n[15:0]},
          {16'd1, 16'd1, 16'd1});
    check("awstall_rsp_before_aw", rsp_early, 64'd0);

    // ---- read error held while the requester stalls the response ----
    clear_counts();
    s_rdata = 32'h0BAD_0BAD;
    s_rresp = 2'b10;
    bus.icb_rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_8000, 32'h0, 4'h0, 2'd2);
    wait_rsp(lat, rdata, err, seen);
    stable = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.icb_rsp_valid && bus.icb_rsp_err && bus.icb_rsp_rdata == 32'h0BAD_0BAD)
        stable++;
      if (k < 3) step();
    end
    bus.icb_rsp_ready = 1'b1;
    step();
    check("rsp_hold_stable", stable, 64'd4);
    check("rsp_hold_release", {62'd0, bus.icb_cmd_ready, bus.icb_rsp_valid}, 64'b10);
    s_rresp = 2'b00;

    // ---- reset while waiting on ARREADY ----
    clear_counts();
    ar_stall = 20;
    issue(1'b1, 32'h0000_9000, 32'h0, 4'h0, 2'd2);
    step();
    check("rst_pre_arvalid", {63'd0, bus.axi_arvalid}, 64'd1);
    rst = 1'b1;
    step();
    check("rst_mid_state",
          {61'd0, bus.axi_arvalid, bus.icb_cmd_ready, bus.icb_rsp_valid}, 64'b010);
    rst = 1'b0;
    ar_stall = 0;
    stable = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.icb_rsp_valid || bus.axi_arvalid) stable++;
    end
    check("rst_no_rsp", stable, 64'd0);

    // ---- misaligned word read ----
    clear_counts();
    s_rdata = 32'h7777_1002;
    issue(1'b1, 32'h0000_1002, 32'h0, 4'h0, 2'd2);
    wait_rsp(lat, rdata, err, seen);
    step();
`ifdef N101_ICB2AXI_ALIGN_CHK_EN
    check("misalign_err", {63'd0, err}, 64'd1);
    check("misalign_rdata", {32'd0, rdata}, 64'd0);
    check("misalign_ar_beats", ar_n, 64'd0);
`else
    check("misalign_err", {63'd0, err}, 64'd0);
    check("misalign_rdata", {32'd0, rdata}, 64'h7777_1002);
    check("misalign_ar_beats", ar_n, 64'd1);
    check("misalign_araddr", {32'd0, last_addr}, 64'h1002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
